// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: operation modes, FSM encodings, sizing helper.
package shift_pkg;

  localparam logic [2:0] MODE_LSL       = 3'd0;
  localparam logic [2:0] MODE_LSR       = 3'd1;
  localparam logic [2:0] MODE_ASR       = 3'd2;
  localparam logic [2:0] MODE_ASR_TRUNC = 3'd3;
  localparam logic [2:0] MODE_ROL       = 3'd4;
  localparam logic [2:0] MODE_ROR       = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;

  // Ceiling log2 for parameter sizing; elaboration-time only.
  function automatic int unsigned shift_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter: one step of the selected mode plus the bit it ejects.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_c,
  output logic             bit_out_c,
  output logic             ovf_bit_c
);

  always_comb begin
    next_c    = value;
    bit_out_c = 1'b0;
    ovf_bit_c = 1'b0;
    case (mode)
      MODE_LSL: begin
        next_c    = {value[WIDTH-2:0], 1'b0};
        bit_out_c = value[WIDTH-1];
        ovf_bit_c = value[WIDTH-1] ^ value[WIDTH-2];
      end
      MODE_LSR: begin
        next_c    = {1'b0, value[WIDTH-1:1]};
        bit_out_c = value[0];
      end
      MODE_ASR, MODE_ASR_TRUNC: begin
        next_c    = {value[WIDTH-1], value[WIDTH-1:1]};
        bit_out_c = value[0];
      end
      // Rotates never eject a bit, so carry stays clear.
      MODE_ROL: next_c = {value[WIDTH-2:0], value[WIDTH-1]};
      MODE_ROR: next_c = {value[0], value[WIDTH-1:1]};
      default:  next_c = value;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shift/rotate unit: one bit position per clock behind a start/busy/done handshake.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = shift_clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  logic [1:0]       state, state_nxt;
  logic [2:0]       op_mode, op_mode_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             busy_nxt, done_nxt, carry_nxt, ovf_nxt, err_nxt;

  logic [WIDTH-1:0] step_c;
  logic             step_bit_c, step_ovf_c;
  logic             reserved_c;
  logic [SHW-1:0]   amount_c;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode      (op_mode),
    .value     (work),
    .next_c    (step_c),
    .bit_out_c (step_bit_c),
    .ovf_bit_c (step_ovf_c)
  );

  // Effective step count: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
  always_comb begin
    reserved_c = (mode > MODE_ROR);
    amount_c   = '0;
    if (mode == MODE_ROL || mode == MODE_ROR) begin
      amount_c = SHW'(shamt % SHW'(WIDTH));
    end else if (!reserved_c) begin
      amount_c = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_mode <= MODE_LSL;
      cnt     <= '0;
      work    <= '0;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_mode <= op_mode_nxt;
      cnt     <= cnt_nxt;
      work    <= work_nxt;
      dout    <= dout_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      carry   <= carry_nxt;
      ovf     <= ovf_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_mode_nxt = op_mode;
    cnt_nxt     = cnt;
    work_nxt    = work;
    dout_nxt    = dout;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    carry_nxt   = carry;
    ovf_nxt     = ovf;
    err_nxt     = err;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_mode_nxt = mode;
          work_nxt    = din;
          carry_nxt   = 1'b0;
          ovf_nxt     = 1'b0;
          err_nxt     = reserved_c;
          if (amount_c == '0) begin
            dout_nxt = din;
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
          end else begin
            cnt_nxt   = amount_c;
            busy_nxt  = 1'b1;
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_nxt  = step_c;
        carry_nxt = carry | step_bit_c;
        ovf_nxt   = ovf | step_ovf_c;
        cnt_nxt   = cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          if (op_mode == MODE_ASR_TRUNC) begin
            state_nxt = ST_ROUND;
          end else begin
            dout_nxt  = step_c;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
      end
      // Floor result is one below the truncated one when a negative operand lost set bits.
      ST_ROUND: begin
        dout_nxt  = (work[WIDTH-1] && carry) ? work + WIDTH'(1) : work;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit at WIDTH=8.
module tb_seq_shift_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SHW   = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       mode;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy, done, carry, ovf, err;

  int checks;
  int failures;

  seq_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .din   (din),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .carry (carry),
    .ovf   (ovf),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation from the post-edge phase; returns in the done cycle with its cycle number (-1 on timeout).
  task automatic run_op(input logic [2:0] m, input logic [SHW-1:0] s, input logic [WIDTH-1:0] d,
                        output int cyc);
    mode  = m;
    shamt = s;
    din   = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; shamt = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dout, busy, done, carry, ovf, err} !== 13'd0) begin failures++;
      $display("FAIL reset_outputs got dout=%h busy=%b done=%b carry=%b ovf=%b err=%b want all 0", dout, busy, done, carry, ovf, err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lsl();
    int cyc;
    run_op(3'd0, 4'd3, 8'h13, cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL lsl_latency got %0d want 4", cyc); end
    checks++; if ({dout, carry, ovf} !== {8'h98, 1'b0, 1'b1}) begin failures++;
      $display("FAIL lsl_result got dout=%h carry=%b ovf=%b want 98 0 1", dout, carry, ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lsl_busy_in_done got %b want 0", busy); end
  endtask

  task automatic test_asr();
    int cyc;
    run_op(3'd2, 4'd2, 8'hED, cyc);
    checks++; if ({cyc == 3, dout, carry} !== {1'b1, 8'hFB, 1'b1}) begin failures++;
      $display("FAIL asr_floor got cyc=%0d dout=%h carry=%b want 3 FB 1", cyc, dout, carry); end
    run_op(3'd3, 4'd2, 8'hED, cyc);
    checks++; if ({cyc == 4, dout, carry} !== {1'b1, 8'hFC, 1'b1}) begin failures++;
      $display("FAIL asr_trunc got cyc=%0d dout=%h carry=%b want 4 FC 1", cyc, dout, carry); end
    run_op(3'd2, 4'd8, 8'h80, cyc);
    checks++; if ({cyc == 9, dout} !== {1'b1, 8'hFF}) begin failures++;
      $display("FAIL asr_full got cyc=%0d dout=%h want 9 FF", cyc, dout); end
    run_op(3'd3, 4'd8, 8'h80, cyc);
    checks++; if ({cyc == 10, dout} !== {1'b1, 8'h00}) begin failures++;
      $display("FAIL asr_trunc_min got cyc=%0d dout=%h want 10 00", cyc, dout); end
    run_op(3'd3, 4'd2, 8'h14, cyc);
    checks++; if ({cyc == 4, dout, carry} !== {1'b1, 8'h05, 1'b0}) begin failures++;
      $display("FAIL asr_trunc_pos got cyc=%0d dout=%h carry=%b want 4 05 0", cyc, dout, carry); end
  endtask

  task automatic test_rotate();
    int cyc;
    run_op(3'd5, 4'd9, 8'hA5, cyc);
    checks++; if ({cyc == 2, dout, carry} !== {1'b1, 8'hD2, 1'b0}) begin failures++;
      $display("FAIL ror_wrap got cyc=%0d dout=%h carry=%b want 2 D2 0", cyc, dout, carry); end
    run_op(3'd4, 4'd8, 8'h81, cyc);
    checks++; if ({cyc == 1, dout} !== {1'b1, 8'h81}) begin failures++;
      $display("FAIL rol_full got cyc=%0d dout=%h want 1 81", cyc, dout); end
    run_op(3'd4, 4'd3, 8'h81, cyc);
    checks++; if ({cyc == 4, dout, carry} !== {1'b1, 8'h0C, 1'b0}) begin failures++;
      $display("FAIL rol_3 got cyc=%0d dout=%h carry=%b want 4 0C 0", cyc, dout, carry); end
  endtask

  task automatic test_lsr();
    int cyc;
    run_op(3'd1, 4'd8, 8'hFF, cyc);
    checks++; if ({cyc == 9, dout, carry} !== {1'b1, 8'h00, 1'b1}) begin failures++;
      $display("FAIL lsr_full got cyc=%0d dout=%h carry=%b want 9 00 1", cyc, dout, carry); end
    run_op(3'd1, 4'd12, 8'hFF, cyc);
    checks++; if ({cyc == 9, dout, carry} !== {1'b1, 8'h00, 1'b1}) begin failures++;
      $display("FAIL lsr_sat got cyc=%0d dout=%h carry=%b want 9 00 1", cyc, dout, carry); end
    // Result must hold with no further pulses while idle.
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({dout, done, busy} !== {8'h00, 1'b0, 1'b0}) begin failures++;
      $display("FAIL lsr_hold got dout=%h done=%b busy=%b want 00 0 0", dout, done, busy); end
  endtask

  task automatic test_zero_reserved();
    int cyc;
    run_op(3'd0, 4'd0, 8'h5A, cyc);
    checks++; if ({cyc == 1, dout, err, carry} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin failures++;
      $display("FAIL zero_amount got cyc=%0d dout=%h err=%b carry=%b want 1 5A 0 0", cyc, dout, err, carry); end
    run_op(3'd6, 4'd5, 8'h3C, cyc);
    checks++; if ({cyc == 1, dout, err} !== {1'b1, 8'h3C, 1'b1}) begin failures++;
      $display("FAIL reserved got cyc=%0d dout=%h err=%b want 1 3C 1", cyc, dout, err); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(3'd0, 4'd1, 8'h01, cyc);
    checks++; if ({cyc == 2, dout, err} !== {1'b1, 8'h02, 1'b0}) begin failures++;
      $display("FAIL b2b_first got cyc=%0d dout=%h err=%b want 2 02 0", cyc, dout, err); end
    run_op(3'd1, 4'd7, 8'h80, cyc);
    checks++; if ({cyc == 8, dout, carry, ovf, err} !== {1'b1, 8'h01, 3'b000}) begin failures++;
      $display("FAIL b2b_second got cyc=%0d dout=%h c/o/e=%b%b%b want 8 01 000", cyc, dout, carry, ovf, err); end
  endtask

  task automatic test_ignore_start();
    int pulses;
    int first;
    mode = 3'd0; shamt = 4'd6; din = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; first = -1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        mode = 3'd1; shamt = 4'd1; din = 8'hF0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_cycle1 got %b want 1", busy); end
      end
      if (done) begin
        pulses++;
        if (first < 0) first = c;
      end
      @(posedge clk); #1;
    end
    checks++; if ({pulses == 1, first == 7} !== 2'b11) begin failures++;
      $display("FAIL ignore_start got pulses=%0d first=%0d want 1 7", pulses, first); end
    checks++; if ({dout, carry, ovf} !== {8'hC0, 1'b0, 1'b1}) begin failures++;
      $display("FAIL ignore_start_result got dout=%h carry=%b ovf=%b want C0 0 1", dout, carry, ovf); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    mode = 3'd0; shamt = 4'd6; din = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if ({dout, busy, done, carry, ovf, err} !== 13'd0) begin failures++;
      $display("FAIL reset_abort got dout=%h busy=%b done=%b carry=%b ovf=%b err=%b want all 0", dout, busy, done, carry, ovf, err); end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if ({pulses == 0, busy} !== 2'b10) begin failures++;
      $display("FAIL reset_no_done got pulses=%0d busy=%b want 0 0", pulses, busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_lsl();
    test_asr();
    test_rotate();
    test_lsr();
    test_zero_reserved();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
